// File: rtl/branch_pkg.sv
// Shared definitions for the iterative branch comparator: RV32 branch funct3 codes,
// FSM state type and the branch-condition decode.
package branch_pkg;

    localparam logic [2:0] BR_BEQ  = 3'b000;
    localparam logic [2:0] BR_BNE  = 3'b001;
    localparam logic [2:0] BR_BLT  = 3'b100;
    localparam logic [2:0] BR_BGE  = 3'b101;
    localparam logic [2:0] BR_BLTU = 3'b110;
    localparam logic [2:0] BR_BGEU = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } br_state_e;

    function automatic logic br_illegal(input logic [2:0] f3);
        return (f3[2:1] == 2'b01);
    endfunction

    // Illegal codes fall into the default arm and never take.
    function automatic logic br_resolve(input logic [2:0] f3, input logic eq, input logic lt);
        logic taken;
        case (f3)
            BR_BEQ:           taken = eq;
            BR_BNE:           taken = ~eq;
            BR_BLT, BR_BLTU:  taken = lt;
            BR_BGE, BR_BGEU:  taken = ~lt;
            default:          taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/branch_slice_cmp.sv
// Combinational unsigned compare of one W-bit operand slice.
module branch_slice_cmp #(
    parameter int W = 8
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic         eq_o,
    output logic         lt_o
);

    assign eq_o = (a_i == b_i);
    assign lt_o = (a_i < b_i);

endmodule

// File: rtl/branch_comp_iter.sv
// Iterative RV32 branch comparator: walks the operands SLICE bits per cycle, MSB first,
// with optional early exit on the first differing slice.
module branch_comp_iter
    import branch_pkg::*;
#(
    parameter int N          = 32,
    parameter int SLICE      = 8,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] br_data0,
    input  logic [N-1:0] br_data1,
    input  logic         br_un,
    input  logic [2:0]   funct3,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         br_eq,
    output logic         br_lt,
    output logic         br_taken,
    output logic         illegal
);

    localparam int NSL = N / SLICE;
    localparam int CW  = $clog2(NSL) + 1;
    localparam logic [SLICE-1:0] SIGN_MASK = SLICE'(1) << (SLICE - 1);

    if (SLICE < 1 || (N % SLICE) != 0) begin : g_param_chk
        $error("branch_comp_iter: N (%0d) must be a multiple of SLICE (%0d)", N, SLICE);
    end

    br_state_e      state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [N-1:0]   a_q, a_d, b_q, b_d;
    logic           un_q, un_d;
    logic [2:0]     f3_q, f3_d;
    logic           eq_acc_q, eq_acc_d, lt_acc_q, lt_acc_d;
    logic           out_valid_q, out_valid_d;
    logic           eq_q, eq_d, lt_q, lt_d, taken_q, taken_d, ill_q, ill_d;

    logic [SLICE-1:0] sl_a, sl_b;
    logic             sl_eq, sl_lt, sign_fix, last, diff_now, eq_fin, lt_fin;
    logic [N-1:0]     a_shl, b_shl;

    // Operands shift left each cycle so the slice under compare is always the top one.
    if (NSL > 1) begin : g_shift
        assign a_shl = {a_q[N-SLICE-1:0], {SLICE{1'b0}}};
        assign b_shl = {b_q[N-SLICE-1:0], {SLICE{1'b0}}};
    end else begin : g_noshift
        assign a_shl = '0;
        assign b_shl = '0;
    end

    // Flipping both sign bits maps two's complement order onto unsigned order.
    assign sign_fix = (cnt_q == '0) && !un_q;
    assign sl_a     = a_q[N-1 -: SLICE] ^ (sign_fix ? SIGN_MASK : '0);
    assign sl_b     = b_q[N-1 -: SLICE] ^ (sign_fix ? SIGN_MASK : '0);

    branch_slice_cmp #(.W(SLICE)) u_slice_cmp (
        .a_i  (sl_a),
        .b_i  (sl_b),
        .eq_o (sl_eq),
        .lt_o (sl_lt)
    );

    assign last     = (cnt_q == CW'(NSL - 1));
    assign diff_now = eq_acc_q & ~sl_eq;
    assign eq_fin   = eq_acc_q & sl_eq;
    assign lt_fin   = diff_now ? sl_lt : lt_acc_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        a_d         = a_q;
        b_d         = b_q;
        un_d        = un_q;
        f3_d        = f3_q;
        eq_acc_d    = eq_acc_q;
        lt_acc_d    = lt_acc_q;
        out_valid_d = out_valid_q;
        eq_d        = eq_q;
        lt_d        = lt_q;
        taken_d     = taken_q;
        ill_d       = ill_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d      = br_data0;
                    b_d      = br_data1;
                    un_d     = br_un;
                    f3_d     = funct3;
                    cnt_d    = '0;
                    eq_acc_d = 1'b1;
                    lt_acc_d = 1'b0;
                    state_d  = S_BUSY;
                end
            end
            S_BUSY: begin
                cnt_d    = cnt_q + 1'b1;
                a_d      = a_shl;
                b_d      = b_shl;
                eq_acc_d = eq_fin;
                lt_acc_d = lt_fin;
                if (last || (EARLY_EXIT && diff_now)) begin
                    state_d     = S_DONE;
                    out_valid_d = 1'b1;
                    eq_d        = eq_fin;
                    lt_d        = lt_fin;
                    taken_d     = br_resolve(f3_q, eq_fin, lt_fin);
                    ill_d       = br_illegal(f3_q);
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d     = S_IDLE;
                    out_valid_d = 1'b0;
                    eq_d        = 1'b0;
                    lt_d        = 1'b0;
                    taken_d     = 1'b0;
                    ill_d       = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Flush overrides everything, including a same-cycle accept in IDLE.
        if (flush) begin
            state_d     = S_IDLE;
            out_valid_d = 1'b0;
            eq_d        = 1'b0;
            lt_d        = 1'b0;
            taken_d     = 1'b0;
            ill_d       = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            un_q        <= 1'b0;
            f3_q        <= '0;
            eq_acc_q    <= 1'b1;
            lt_acc_q    <= 1'b0;
            out_valid_q <= 1'b0;
            eq_q        <= 1'b0;
            lt_q        <= 1'b0;
            taken_q     <= 1'b0;
            ill_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            un_q        <= un_d;
            f3_q        <= f3_d;
            eq_acc_q    <= eq_acc_d;
            lt_acc_q    <= lt_acc_d;
            out_valid_q <= out_valid_d;
            eq_q        <= eq_d;
            lt_q        <= lt_d;
            taken_q     <= taken_d;
            ill_q       <= ill_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = out_valid_q;
    assign br_eq     = eq_q;
    assign br_lt     = lt_q;
    assign br_taken  = taken_q;
    assign illegal   = ill_q;

endmodule

// File: tb/tb_branch_comp_iter.sv
// Scoreboard bench: two comparators (fixed latency and early exit) driven in lockstep.
module tb_branch_comp_iter;

    localparam int NSL = 4;

    typedef struct {
        logic        eq;
        logic        lt;
        logic        taken;
        logic        ill;
        int unsigned lat;
        int unsigned acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        un = 1'b0;
    logic [2:0]  f3 = '0;
    logic        out_ready = 1'b0;
    logic [1:0]  ir, ov, eqo, lto, tko, ilo;

    int unsigned cyc = 0;
    int unsigned n_chk = 0;
    int unsigned n_pass = 0;
    exp_t        q0[$];
    exp_t        q1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    branch_comp_iter #(.N(32), .SLICE(8), .EARLY_EXIT(1'b0)) u_dut0 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir[0]),
        .br_data0(a), .br_data1(b), .br_un(un), .funct3(f3),
        .out_valid(ov[0]), .out_ready(out_ready), .br_eq(eqo[0]), .br_lt(lto[0]),
        .br_taken(tko[0]), .illegal(ilo[0])
    );

    branch_comp_iter #(.N(32), .SLICE(8), .EARLY_EXIT(1'b1)) u_dut1 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir[1]),
        .br_data0(a), .br_data1(b), .br_un(un), .funct3(f3),
        .out_valid(ov[1]), .out_ready(out_ready), .br_eq(eqo[1]), .br_lt(lto[1]),
        .br_taken(tko[1]), .illegal(ilo[1])
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        n_chk++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, expv, $time);
    endtask

    function automatic exp_t model(input logic [31:0] ma, input logic [31:0] mb,
                                   input logic mun, input logic [2:0] mf3);
        exp_t e;
        e.eq  = (ma == mb);
        e.lt  = mun ? (ma < mb) : ($signed(ma) < $signed(mb));
        e.ill = (mf3 == 3'b010) || (mf3 == 3'b011);
        case (mf3)
            3'b000:         e.taken = e.eq;
            3'b001:         e.taken = !e.eq;
            3'b100, 3'b110: e.taken = e.lt;
            3'b101, 3'b111: e.taken = !e.lt;
            default:        e.taken = 1'b0;
        endcase
        e.lat = NSL;
        e.acc = 0;
        return e;
    endfunction

    // Early-exit latency: one cycle per byte up to and including the first differing byte.
    function automatic int unsigned ee_lat(input logic [31:0] ma, input logic [31:0] mb);
        logic [31:0] x;
        x = ma ^ mb;
        for (int i = 0; i < NSL; i++)
            if (x[31 - 8*i -: 8] != 8'h00) return i + 1;
        return NSL;
    endfunction

    task automatic wait_ready();
        @(negedge clk);
        for (int i = 0; i < 50 && ir != 2'b11; i++) @(negedge clk);
        if (ir != 2'b11) chk("ready_timeout", 64'(ir), 64'd3);
    endtask

    task automatic send(input logic [31:0] ta, input logic [31:0] tb2,
                        input logic tun, input logic [2:0] tf3);
        exp_t e;
        wait_ready();
        e = model(ta, tb2, tun, tf3);
        a = ta; b = tb2; un = tun; f3 = tf3; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        e.acc = cyc;
        e.lat = NSL;
        q0.push_back(e);
        e.lat = ee_lat(ta, tb2);
        q1.push_back(e);
    endtask

    task automatic finish(input int unsigned stall);
        for (int i = 0; i < 20 && ov != 2'b11; i++) @(negedge clk);
        if (ov != 2'b11) chk("done_timeout", 64'(ov), 64'd3);
        repeat (stall) @(negedge clk);
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic issue(input logic [31:0] ta, input logic [31:0] tb2, input logic tun,
                         input logic [2:0] tf3, input int unsigned stall);
        send(ta, tb2, tun, tf3);
        finish(stall);
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_ov"},  64'(ov),  64'd0);
        chk({nm, "_eq"},  64'(eqo), 64'd0);
        chk({nm, "_lt"},  64'(lto), 64'd0);
        chk({nm, "_tk"},  64'(tko), 64'd0);
        chk({nm, "_ill"}, 64'(ilo), 64'd0);
    endtask

    task automatic do_reset_release();
        @(negedge clk);
        #1 rst = 1'b0;
        q0.delete();
        q1.delete();
    endtask

    // Monitor: pops an expectation when a result appears and checks it every held cycle.
    exp_t       cur[2];
    logic [1:0] held = '0;
    logic [1:0] bad = '0;
    logic [1:0] idle_chk = '0;

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                held = '0;
                idle_chk = '0;
            end else begin
                for (int k = 0; k < 2; k++) begin
                    if (idle_chk[k]) begin
                        chk($sformatf("d%0d_idle_ready", k), 64'(ir[k]), 64'd1);
                        chk($sformatf("d%0d_idle_valid", k), 64'(ov[k]), 64'd0);
                        idle_chk[k] = 1'b0;
                    end else if (ov[k]) begin
                        if (!held[k]) begin
                            bad[k] = (k == 0) ? (q0.size() == 0) : (q1.size() == 0);
                            if (bad[k]) begin
                                chk($sformatf("d%0d_unexpected_valid", k), 64'(ov[k]), 64'd0);
                            end else begin
                                if (k == 0) cur[k] = q0.pop_front();
                                else        cur[k] = q1.pop_front();
                                chk($sformatf("d%0d_latency", k), 64'(cyc - cur[k].acc),
                                    64'(cur[k].lat));
                            end
                            held[k] = 1'b1;
                        end
                        if (!bad[k]) begin
                            chk($sformatf("d%0d_eq", k),    64'(eqo[k]), 64'(cur[k].eq));
                            chk($sformatf("d%0d_lt", k),    64'(lto[k]), 64'(cur[k].lt));
                            chk($sformatf("d%0d_taken", k), 64'(tko[k]), 64'(cur[k].taken));
                            chk($sformatf("d%0d_ill", k),   64'(ilo[k]), 64'(cur[k].ill));
                            chk($sformatf("d%0d_busy_ready", k), 64'(ir[k]), 64'd0);
                        end
                        if (out_ready) begin
                            held[k] = 1'b0;
                            idle_chk[k] = 1'b1;
                        end
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        // Reset with a request presented: must be ignored.
        a = 32'h1234_5678; b = 32'h0; f3 = 3'b000; in_valid = 1'b1;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        chk("reset_ready", 64'(ir), 64'd3);
        in_valid = 1'b0;
        do_reset_release();
        repeat (2) @(negedge clk);
        chk("post_reset_ready", 64'(ir), 64'd3);
        chk("post_reset_valid", 64'(ov), 64'd0);

        // Directed cases.
        issue(32'd5, 32'd5, 1'b0, 3'b000, 0);
        issue(32'hFFFF_FFFF, 32'd1, 1'b0, 3'b100, 1);
        issue(32'hFFFF_FFFF, 32'd1, 1'b1, 3'b110, 0);
        issue(32'h8000_0000, 32'd0, 1'b1, 3'b111, 3);
        issue(32'h8000_0000, 32'd0, 1'b0, 3'b101, 0);
        issue(32'h0000_0100, 32'h0000_0101, 1'b0, 3'b010, 2);
        issue(32'h7FFF_FFFF, 32'h8000_0000, 1'b0, 3'b011, 0);

        // Flush during the second busy cycle: request dropped.
        wait_ready();
        a = 32'h1234_5678; b = 32'h1234_5678; un = 1'b0; f3 = 3'b000; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        chk("flush_ready", 64'(ir), 64'd3);
        chk_all_zero("flush");
        repeat (6) @(negedge clk);
        chk("flush_no_valid", 64'(ov), 64'd0);
        issue(32'd3, 32'd7, 1'b0, 3'b001, 0);

        // Flush together with in_valid in IDLE: nothing accepted.
        wait_ready();
        a = 32'd9; b = 32'd9; f3 = 3'b000; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0; flush = 1'b0;
        chk("flush_idle_ready", 64'(ir), 64'd3);
        repeat (6) @(negedge clk);
        chk("flush_idle_no_valid", 64'(ov), 64'd0);

        // Asynchronous reset mid-busy.
        send(32'hAAAA_5555, 32'hAAAA_5555, 1'b1, 3'b000);
        #2 rst = 1'b1;
        #1;
        chk("rst_busy_ready", 64'(ir), 64'd3);
        chk_all_zero("rst_busy");
        do_reset_release();

        // Asynchronous reset while a result is being held.
        send(32'd42, 32'd42, 1'b0, 3'b000);
        for (int i = 0; i < 20 && ov != 2'b11; i++) @(negedge clk);
        chk("rst_done_valid", 64'(ov), 64'd3);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("rst_done_ready", 64'(ir), 64'd3);
        chk_all_zero("rst_done");
        do_reset_release();
        issue(32'd100, 32'd200, 1'b1, 3'b110, 1);

        // Randomised traffic.
        for (int n = 0; n < 60; n++) begin
            logic [31:0] ra, rb;
            ra = $urandom;
            case ($urandom_range(0, 3))
                0: rb = $urandom;
                1: rb = ra;
                2: rb = ra ^ (32'd1 << $urandom_range(0, 31));
                default: begin
                    ra = {ra[31], 23'd0, ra[7:0]};
                    rb = $urandom;
                    rb = {rb[31], 23'd0, rb[7:0]};
                end
            endcase
            issue(ra, rb, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                  $urandom_range(0, 3));
        end

        repeat (4) @(negedge clk);
        chk("final_q0_empty", 64'(q0.size()), 64'd0);
        chk("final_q1_empty", 64'(q1.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
